// File: rtl/latq_bank_wr_ctrl_pkg.sv
// rtl/latq_bank_wr_ctrl_pkg.sv - shared types and helpers for the latch bank write sequencer
// Contents: wr_state_t sequencer states, cnt_w() counter width, onehot() word enable decode.
package latq_wr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } wr_state_t;

    // Width of one down-counter that must hold the largest phase length minus one.
    function automatic int cnt_w(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
        int m;
        m = setup_cyc;
        if (pulse_cyc > m) m = pulse_cyc;
        if (hold_cyc > m)  m = hold_cyc;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // One-hot word enable; an address outside the bank decodes to all zeros.
    function automatic logic [63:0] onehot(input int unsigned idx, input int unsigned words);
        logic [63:0] v;
        v = '0;
        if (idx < words) v = 64'd1 << idx;
        return v;
    endfunction

endpackage

// File: rtl/latq_bank_wr_ctrl_if.sv
// rtl/latq_bank_wr_ctrl_if.sv - two-requester write request bundle
// Signals: A_/B_ VALID, READY, ADDR[AW], DATA[WIDTH]. master = requester side, slave = sequencer side.
interface latq_bank_wr_ctrl_if #(
    parameter int WORDS = 8,
    parameter int WIDTH = 8
);
    localparam int AW = $clog2(WORDS);

    logic             A_VALID;
    logic             A_READY;
    logic [AW-1:0]    A_ADDR;
    logic [WIDTH-1:0] A_DATA;
    logic             B_VALID;
    logic             B_READY;
    logic [AW-1:0]    B_ADDR;
    logic [WIDTH-1:0] B_DATA;

    modport master (
        output A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA,
        input  A_READY, B_READY
    );

    modport slave (
        input  A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA,
        output A_READY, B_READY
    );
endinterface

// File: rtl/latq_bank_wr_ctrl_rr_arb2.sv
// rtl/latq_bank_wr_ctrl_rr_arb2.sv - two-way round-robin arbiter
// Ports: i_clk, i_rst (async high), i_a_valid, i_b_valid, i_en (arbitration window),
//        o_a_gnt, o_b_gnt (combinational; a grant is an accept at the next edge).
module latq_rr_arb2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_a_valid,
    input  logic i_b_valid,
    input  logic i_en,
    output logic o_a_gnt,
    output logic o_b_gnt
);
    // 0: A wins a tie, 1: B wins a tie.
    logic r_ptr_b;

    assign o_a_gnt = i_en & i_a_valid & (~i_b_valid | ~r_ptr_b);
    assign o_b_gnt = i_en & i_b_valid & (~i_a_valid |  r_ptr_b);

    // Priority passes to the side that did not win, even when it was not requesting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr_b <= 1'b0;
        end else if (o_a_gnt) begin
            r_ptr_b <= 1'b1;
        end else if (o_b_gnt) begin
            r_ptr_b <= 1'b0;
        end
    end
endmodule

// File: rtl/latq_bank_wr_ctrl.sv
// rtl/latq_bank_wr_ctrl.sv - write sequencer and arbiter for a bank of transparent-high latches
// Ports: CLK, RST (async high); bus (slave modport of latq_bank_wr_ctrl_if, two requesters);
//        LAT_D shared latch data, LAT_E one-hot word enables, BUSY, GNT_B (owner of last write).
// Optional (LATQ_WR_RDBK_EN): LAT_Q latch outputs in, RD_ADDR in, RD_DATA registered word out,
//        CMP_ERR one-cycle pulse when the written word reads back different from LAT_D.
module latq_bank_wr_ctrl
    import latq_wr_pkg::*;
#(
    parameter int WORDS     = 8,
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    latq_bank_wr_ctrl_if.slave     bus,
`ifdef LATQ_WR_RDBK_EN
    input  logic [WORDS*WIDTH-1:0] LAT_Q,
    input  logic [$clog2(WORDS)-1:0] RD_ADDR,
    output logic [WIDTH-1:0]       RD_DATA,
    output logic                   CMP_ERR,
`endif
    output logic [WIDTH-1:0]       LAT_D,
    output logic [WORDS-1:0]       LAT_E,
    output logic                   BUSY,
    output logic                   GNT_B
);
    localparam int AW = $clog2(WORDS);
    localparam int CW = cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);

    wr_state_t        r_state;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_addr;
    logic [WIDTH-1:0] r_lat_d;
    logic [WORDS-1:0] r_lat_e;
    logic             r_busy;
    logic             r_gnt_b;
    logic             w_a_gnt;
    logic             w_b_gnt;

    latq_rr_arb2 u_arb (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_a_valid (bus.A_VALID),
        .i_b_valid (bus.B_VALID),
        .i_en      (r_state == IDLE),
        .o_a_gnt   (w_a_gnt),
        .o_b_gnt   (w_b_gnt)
    );

    assign bus.A_READY = w_a_gnt;
    assign bus.B_READY = w_b_gnt;

    // Latch pins come straight from flops so LAT_E cannot glitch.
    assign LAT_D = r_lat_d;
    assign LAT_E = r_lat_e;
    assign BUSY  = r_busy;
    assign GNT_B = r_gnt_b;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_lat_d <= '0;
            r_lat_e <= '0;
            r_busy  <= 1'b0;
            r_gnt_b <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_a_gnt || w_b_gnt) begin
                        r_addr  <= w_b_gnt ? bus.B_ADDR : bus.A_ADDR;
                        r_lat_d <= w_b_gnt ? bus.B_DATA : bus.A_DATA;
                        r_gnt_b <= w_b_gnt;
                        r_busy  <= 1'b1;
                        r_cnt   <= CW'(SETUP_CYC - 1);
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_cnt == '0) begin
                        r_lat_e <= WORDS'(onehot(32'(r_addr), WORDS));
                        r_cnt   <= CW'(PULSE_CYC - 1);
                        r_state <= PULSE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                PULSE: begin
                    if (r_cnt == '0) begin
                        r_lat_e <= '0;
                        r_cnt   <= CW'(HOLD_CYC - 1);
                        r_state <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef LATQ_WR_RDBK_EN
    logic [WIDTH-1:0] r_rd_data;
    logic             r_cmp_err;
    logic [WIDTH-1:0] w_rd_word;
    logic [WIDTH-1:0] w_wr_word;
    logic             w_wr_in_bank;

    assign w_rd_word    = (32'(RD_ADDR) < WORDS) ? LAT_Q[32'(RD_ADDR)*WIDTH +: WIDTH] : '0;
    assign w_wr_in_bank = 32'(r_addr) < WORDS;
    assign w_wr_word    = w_wr_in_bank ? LAT_Q[32'(r_addr)*WIDTH +: WIDTH] : '0;

    // The latch closed at the end of PULSE, so by the last HOLD cycle it shows the stored word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rd_data <= '0;
            r_cmp_err <= 1'b0;
        end else begin
            r_rd_data <= w_rd_word;
            r_cmp_err <= (r_state == HOLD) && (r_cnt == '0) && w_wr_in_bank
                         && (w_wr_word != r_lat_d);
        end
    end

    assign RD_DATA = r_rd_data;
    assign CMP_ERR = r_cmp_err;
`endif

endmodule

// File: tb/tb_latq_bank_wr_ctrl.sv
// tb/tb_latq_bank_wr_ctrl.sv - directed bench for latq_bank_wr_ctrl (default and 6-word configs)
module tb_latq_bank_wr_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    latq_bank_wr_ctrl_if #(.WORDS(8), .WIDTH(8)) bus0 ();
    latq_bank_wr_ctrl_if #(.WORDS(6), .WIDTH(8)) bus1 ();

    logic [7:0]  lat_d0;
    logic [7:0]  lat_e0;
    logic        busy0, gnt0;
    logic [7:0]  lat_d1;
    logic [5:0]  lat_e1;
    logic        busy1, gnt1;
    logic [63:0] lat_q0;

    // Transparent-high latch bank; word 2 bit 0 is stuck at 0.
    for (genvar g = 0; g < 8; g++) begin : g_lat
        logic [7:0] q;
        always_latch if (lat_e0[g]) q <= lat_d0;
        assign lat_q0[g*8 +: 8] = (g == 2) ? (q & 8'hFE) : q;
    end

`ifdef LATQ_WR_RDBK_EN
    logic [2:0] rd_addr0 = 3'd0;
    logic [7:0] rd_data0, rd_data1;
    logic       cmp_err0, cmp_err1;
`endif

    latq_bank_wr_ctrl #(.WORDS(8), .WIDTH(8)) u_dut (
        .CLK     (CLK),
        .RST     (RST),
        .bus     (bus0),
`ifdef LATQ_WR_RDBK_EN
        .LAT_Q   (lat_q0),
        .RD_ADDR (rd_addr0),
        .RD_DATA (rd_data0),
        .CMP_ERR (cmp_err0),
`endif
        .LAT_D   (lat_d0),
        .LAT_E   (lat_e0),
        .BUSY    (busy0),
        .GNT_B   (gnt0)
    );

    latq_bank_wr_ctrl #(.WORDS(6), .WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) u_dut6 (
        .CLK     (CLK),
        .RST     (RST),
        .bus     (bus1),
`ifdef LATQ_WR_RDBK_EN
        .LAT_Q   (48'd0),
        .RD_ADDR (3'd0),
        .RD_DATA (rd_data1),
        .CMP_ERR (cmp_err1),
`endif
        .LAT_D   (lat_d1),
        .LAT_E   (lat_e1),
        .BUSY    (busy1),
        .GNT_B   (gnt1)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Continuous invariants on the default instance, sampled on the falling edge.
    int         viol = 0;
    logic [7:0] prev_d = 8'd0;
    int         cyc = 0;
    always @(posedge CLK) cyc++;
    always @(negedge CLK) begin
        if (lat_e0 != 8'd0 && lat_d0 !== prev_d) viol++;
        if ($countones(lat_e0) > 1) viol++;
        if (busy0 && (bus0.A_READY || bus0.B_READY)) viol++;
        prev_d = lat_d0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int t_prev;
        int n_busy;
        logic [5:0] e_or;

        bus0.A_VALID = 0; bus0.A_ADDR = 0; bus0.A_DATA = 0;
        bus0.B_VALID = 0; bus0.B_ADDR = 0; bus0.B_DATA = 0;
        bus1.A_VALID = 0; bus1.A_ADDR = 0; bus1.A_DATA = 0;
        bus1.B_VALID = 0; bus1.B_ADDR = 0; bus1.B_DATA = 0;

        repeat (2) @(negedge CLK);
        check("rst_busy",  busy0,  0);
        check("rst_lat_e", lat_e0, 0);
        check("rst_lat_d", lat_d0, 0);
        check("rst_gnt_b", gnt0,   0);
        RST = 0;
        @(negedge CLK);

        // Single write A addr 5 data A5
        bus0.A_VALID = 1; bus0.A_ADDR = 3'd5; bus0.A_DATA = 8'hA5;
        #1;
        check("a_ready_idle", bus0.A_READY, 1);
        check("b_ready_idle", bus0.B_READY, 0);
        @(negedge CLK); bus0.A_VALID = 0;
        check("wr_lat_d",  lat_d0, 8'hA5);
        check("wr_setup_e", lat_e0, 0);
        check("wr_busy",   busy0,  1);
        @(negedge CLK); check("wr_pulse1", lat_e0, 8'h20);
        @(negedge CLK); check("wr_pulse2", lat_e0, 8'h20);
        @(negedge CLK); check("wr_hold_e", lat_e0, 0);
        check("wr_hold_busy", busy0, 1);
        @(negedge CLK); check("wr_done_busy", busy0, 0);
        check("wr_latch_q5", lat_q0[5*8 +: 8], 8'hA5);

        // Reset during PULSE of a write to addr 3
        bus0.A_VALID = 1; bus0.A_ADDR = 3'd3; bus0.A_DATA = 8'h33;
        @(negedge CLK); bus0.A_VALID = 0;
        @(negedge CLK); check("rst_pre_pulse", lat_e0, 8'h08);
        #1 RST = 1;
        #1;
        check("rst_async_e",    lat_e0, 0);
        check("rst_async_busy", busy0,  0);
        @(negedge CLK); RST = 0;
        check("rst_rel_gnt", gnt0, 0);

        // Simultaneous A and B from reset: A first, then B
        bus0.A_VALID = 1; bus0.A_ADDR = 3'd1; bus0.A_DATA = 8'h11;
        bus0.B_VALID = 1; bus0.B_ADDR = 3'd2; bus0.B_DATA = 8'h22;
        #1;
        check("tie_a_ready", bus0.A_READY, 1);
        check("tie_b_ready", bus0.B_READY, 0);
        @(negedge CLK); bus0.A_VALID = 0;
        check("tie_gnt_a", gnt0,   0);
        check("tie_d_a",   lat_d0, 8'h11);
        k = 0;
        while (!bus0.B_READY && k < 20) begin @(negedge CLK); k++; end
        check("tie_b_wait", k, 4);
        @(negedge CLK); bus0.B_VALID = 0;
        check("tie_gnt_b", gnt0,   1);
        check("tie_d_b",   lat_d0, 8'h22);
        repeat (4) @(negedge CLK);
        check("tie_q1", lat_q0[1*8 +: 8], 8'h11);
        check("tie_q2", lat_q0[2*8 +: 8], 8'h22);

        // Both held valid: grants alternate A,B,A,B
        bus0.A_VALID = 1; bus0.B_VALID = 1;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            #1;
            while (!(bus0.A_READY || bus0.B_READY) && k < 20) begin @(negedge CLK); #1; k++; end
            check("alt_ready_to", (k < 20), 1);
            @(negedge CLK);
            check("alt_gnt", gnt0, i % 2);
        end
        bus0.A_VALID = 0; bus0.B_VALID = 0;
        repeat (5) @(negedge CLK);

        // Back-to-back A-only writes, accepts spaced S+P+H+1 = 5 cycles
        t_prev = -1;
        bus0.A_VALID = 1; bus0.A_ADDR = 3'd6; bus0.A_DATA = 8'h40;
        for (int i = 0; i < 3; i++) begin
            k = 0;
            #1;
            while (!bus0.A_READY && k < 20) begin @(negedge CLK); #1; k++; end
            if (t_prev >= 0) check("b2b_spacing", cyc - t_prev, 5);
            t_prev = cyc;
            @(negedge CLK);
            check("b2b_d", lat_d0, 8'h40 + 8'(i));
            bus0.A_DATA = 8'h41 + 8'(i);
        end
        bus0.A_VALID = 0;
        repeat (5) @(negedge CLK);
        check("b2b_q6", lat_q0[6*8 +: 8], 8'h42);
        check("invariants", viol, 0);

        // 6-word bank, S=3 P=1 H=2, out-of-range address 7
        bus1.A_VALID = 1; bus1.A_ADDR = 3'd7; bus1.A_DATA = 8'h77;
        @(negedge CLK); bus1.A_VALID = 0;
        check("oor_d", lat_d1, 8'h77);
        n_busy = 0; e_or = '0;
        while (busy1 && n_busy < 20) begin
            e_or |= lat_e1;
            n_busy++;
            @(negedge CLK);
        end
        check("oor_len", n_busy, 6);
        check("oor_e",   e_or,   0);

`ifdef LATQ_WR_RDBK_EN
        // Stuck-at-0 bit on word 2: writing FF reads back FE
        bus0.A_VALID = 1; bus0.A_ADDR = 3'd2; bus0.A_DATA = 8'hFF;
        @(negedge CLK); bus0.A_VALID = 0;
        repeat (3) @(negedge CLK);
        check("cmp_err_pre", cmp_err0, 0);
        @(negedge CLK); check("cmp_err_pulse", cmp_err0, 1);
        @(negedge CLK); check("cmp_err_post",  cmp_err0, 0);
        rd_addr0 = 3'd2;
        @(negedge CLK); check("rd_data_w2", rd_data0, 8'hFE);

        // Healthy word: no compare error
        bus0.A_VALID = 1; bus0.A_ADDR = 3'd4; bus0.A_DATA = 8'h5A;
        @(negedge CLK); bus0.A_VALID = 0;
        repeat (4) @(negedge CLK);
        check("cmp_ok", cmp_err0, 0);
        rd_addr0 = 3'd4;
        @(negedge CLK); check("rd_data_w4", rd_data0, 8'h5A);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/latq_bank_wr_ctrl.md
Name: latq_bank_wr_ctrl

Overview:
Write sequencer and two-port arbiter for a bank of transparent-high D latches (latq_1 cells, one word per enable). It accepts write requests from two requesters and drives shared latch data plus a one-hot per-word latch enable. Each write is sequenced so latch setup, minimum enable pulse width and hold are met by construction. It sits between bus-side register logic and a latch-based register file or configuration bank.

Parameters:
WORDS, 8, number of latch words (one enable bit each), 2..64
WIDTH, 8, bits per word
AW, $clog2(WORDS), address width (derived, not overridable)
SETUP_CYC, 1, cycles LAT_D is stable before LAT_E rises, >=1
PULSE_CYC, 2, cycles LAT_E is high, >=1
HOLD_CYC, 1, cycles LAT_D is held after LAT_E falls, >=1

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
A_VALID  input  1  requester A write request
A_READY  output  1  requester A accepted this cycle when A_VALID also high
A_ADDR  input  AW  requester A word address
A_DATA  input  WIDTH  requester A write data
B_VALID  input  1  requester B write request
B_READY  output  1  requester B accept
B_ADDR  input  AW  requester B word address
B_DATA  input  WIDTH  requester B write data
LAT_D  output  WIDTH  shared data to all latch D pins
LAT_E  output  WORDS  one-hot latch enables, registered
BUSY  output  1  sequence in progress (state != IDLE)
GNT_B  output  1  owner of current/last sequence: 0=A, 1=B

Behaviour:
- Reset (async, RST=1): state IDLE, LAT_E=0, LAT_D=0, BUSY=0, GNT_B=0, round-robin pointer favours A, counter=0. LAT_E cleared immediately on RST assertion, even mid-pulse (truncated pulse accepted; software rewrites after reset).
- States: IDLE -> SETUP -> PULSE -> HOLD -> IDLE. One down-counter reloaded on each transition.
- IDLE: READY combinational from valids and pointer. Only one valid -> that one ready. Both valid -> pointer side ready. READY low in all other states.
- Accept (VALID&READY at edge): capture ADDR/DATA into LAT_D and address register, GNT_B set to winner, pointer moves to loser, enter SETUP, counter=SETUP_CYC-1.
- SETUP: LAT_E=0, LAT_D stable; at counter 0 -> PULSE, counter=PULSE_CYC-1.
- PULSE: LAT_E = one-hot(addr), exactly PULSE_CYC cycles; at 0 -> HOLD, counter=HOLD_CYC-1.
- HOLD: LAT_E=0, LAT_D unchanged; at 0 -> IDLE.
- LAT_E rises first edge after SETUP_CYC cycles from accept; sequence occupies SETUP_CYC+PULSE_CYC+HOLD_CYC cycles; next accept possible on the cycle IDLE is re-entered (back-to-back throughput 1 write per S+P+H+1 cycles).
- LAT_D changes only on accept; holds last value in IDLE.
- LAT_E and LAT_D driven straight from flops (glitch-free latch enables); never more than one bit of LAT_E high.
- Address >= WORDS (non-power-of-2 WORDS): full sequence runs, LAT_E stays 0 (unless feature below).
- VALID/ADDR/DATA changes while BUSY ignored; requester must hold VALID until READY.

Optional Feature:
LATQ_WR_RDBK_EN: adds input LAT_Q[WORDS*WIDTH] and outputs RD_ADDR[AW] (input), RD_DATA[WIDTH] (registered mux of LAT_Q word RD_ADDR, 1-cycle latency, reset 0) and CMP_ERR (1-cycle pulse in the cycle after HOLD ends if written word != LAT_D). Without macro: none of these ports exist, no compare logic.

Decomposition:
- Package latq_wr_pkg: state enum (IDLE, SETUP, PULSE, HOLD; 2-bit), counter width function cnt_w(SETUP_CYC,PULSE_CYC,HOLD_CYC), one-hot decode function.
- One sub-module: latq_rr_arb2 (two-way round-robin arbiter: valids, enable, pointer update on accept, grant outputs).

Test Plan:
- Reset: RST pulsed during PULSE of a write to addr 3 -> LAT_E drops to 0 same cycle asynchronously, BUSY=0, GNT_B=0 after release.
- Single write A addr 5 data 0xA5, defaults -> LAT_D=0xA5 next edge, LAT_E=0x20 for exactly 2 cycles starting 1 cycle after accept, BUSY low 4 cycles after accept; latch model Q=0xA5.
- Simultaneous A(addr1,0x11) and B(addr2,0x22) from reset -> A first, then B; repeated both-valid -> grants alternate A,B,A,B.
- Back-to-back A-only writes -> A_READY high only in IDLE, accepts spaced 5 cycles; LAT_D never changes while LAT_E nonzero.
- SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2, WORDS=6, write addr 7 -> LAT_E stays 0, sequence length 6 cycles.
- With LATQ_WR_RDBK_EN, stuck-at-0 bit injected on word 2, write 0xFF -> CMP_ERR one-cycle pulse; RD_DATA for addr 2 = 0xFE one cycle after RD_ADDR=2.
